// File: rtl/tank_sprite_mapper.sv
// Two-stage pixel colour mapper for tile-aligned tank sprites with programmable
// colours, alive masking and a frame-counted hit flash.
module tank_sprite_mapper #(
  parameter int NUM_TANKS    = 2,
  parameter int COORD_W      = 10,
  parameter int SPRITE_LOG2  = 5,
  parameter int COLOR_W      = 8,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                              Clk,
  input  logic                              Reset_n,
  input  logic                              frame_start,
  input  logic [COORD_W-1:0]                DrawX,
  input  logic [COORD_W-1:0]                DrawY,
  input  logic                              blank,
  input  logic [NUM_TANKS*COORD_W-1:0]      TankX,
  input  logic [NUM_TANKS*COORD_W-1:0]      TankY,
  input  logic [NUM_TANKS-1:0]              tank_alive,
  input  logic [NUM_TANKS-1:0]              hit_pulse,
  input  logic                              cfg_we,
  input  logic [$clog2(NUM_TANKS+1)-1:0]    cfg_idx,
  input  logic [3*COLOR_W-1:0]              cfg_rgb,
  output logic [COLOR_W-1:0]                Red,
  output logic [COLOR_W-1:0]                Green,
  output logic [COLOR_W-1:0]                Blue,
  output logic [$clog2(NUM_TANKS):0]        hit_id,
  output logic [NUM_TANKS-1:0]              flash_active
);

  localparam int IDX_W  = $clog2(NUM_TANKS + 1);
  localparam int HID_W  = $clog2(NUM_TANKS) + 1;
  localparam int TI_W   = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1;
  localparam int TILE_W = COORD_W - SPRITE_LOG2;
  localparam int RGB_W  = 3 * COLOR_W;
  localparam logic [COLOR_W-1:0] C55 = COLOR_W'(8'h55);
  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);

  function automatic logic [RGB_W-1:0] color_default(input int i);
    if (i == NUM_TANKS) return '0;
    else if (i == 0)    return {{COLOR_W{1'b0}}, C55, {COLOR_W{1'b0}}};
    else if (i == 1)    return {{(2*COLOR_W){1'b0}}, C55};
    else                return {C55, C55, C55};
  endfunction

  // Pixel offset within a tile never takes part in the match.
  logic unused_lsbs;
  assign unused_lsbs = ^{DrawX[SPRITE_LOG2-1:0], DrawY[SPRITE_LOG2-1:0], TankX, TankY};

  logic [NUM_TANKS-1:0] tank_hit;
  for (genvar gi = 0; gi < NUM_TANKS; gi++) begin : g_hit
    assign tank_hit[gi] = tank_alive[gi]
      && (DrawX[COORD_W-1:SPRITE_LOG2] == TankX[gi*COORD_W+SPRITE_LOG2 +: TILE_W])
      && (DrawY[COORD_W-1:SPRITE_LOG2] == TankY[gi*COORD_W+SPRITE_LOG2 +: TILE_W]);
  end

  // Scan downward so the lowest-indexed hitting tank is left as the winner.
  logic            any_hit;
  logic [TI_W-1:0] win_idx;
  always_comb begin
    any_hit = 1'b0;
    win_idx = '0;
    for (int i = NUM_TANKS - 1; i >= 0; i--) begin
      if (tank_hit[i]) begin
        any_hit = 1'b1;
        win_idx = TI_W'(i);
      end
    end
  end

  logic            blank1_q;
  logic            hit1_q;
  logic [TI_W-1:0] idx1_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      blank1_q <= 1'b1;
      hit1_q   <= 1'b0;
      idx1_q   <= '0;
    end else begin
      blank1_q <= blank;
      hit1_q   <= any_hit;
      idx1_q   <= win_idx;
    end
  end

  logic [RGB_W-1:0]     color_q [NUM_TANKS+1];
  logic [7:0]           flash_q [NUM_TANKS];
  logic [7:0]           flash_d [NUM_TANKS];
  logic [NUM_TANKS-1:0] flash_active_q;

  always_comb begin
    for (int i = 0; i < NUM_TANKS; i++) begin
      flash_d[i] = flash_q[i];
      if (hit_pulse[i])
        flash_d[i] = FLASH_LOAD;
      else if (frame_start && (flash_q[i] != 8'd0))
        flash_d[i] = flash_q[i] - 8'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i <= NUM_TANKS; i++) color_q[i] <= color_default(i);
      for (int i = 0; i < NUM_TANKS; i++) flash_q[i] <= 8'd0;
      flash_active_q <= '0;
    end else begin
      for (int i = 0; i <= NUM_TANKS; i++) begin
        if (cfg_we && (cfg_idx == IDX_W'(i))) color_q[i] <= cfg_rgb;
      end
      for (int i = 0; i < NUM_TANKS; i++) begin
        flash_q[i]        <= flash_d[i];
        flash_active_q[i] <= (flash_d[i] != 8'd0);
      end
    end
  end

  logic [RGB_W-1:0] rgb_d,  rgb_q;
  logic [HID_W-1:0] hid_d,  hid_q;

  // Odd flash counts render white, giving a blink that toggles every frame.
  always_comb begin
    rgb_d = '0;
    hid_d = '0;
    if (!blank1_q) begin
      if (hit1_q) begin
        rgb_d = flash_q[idx1_q][0] ? {RGB_W{1'b1}} : color_q[idx1_q];
        hid_d = HID_W'(idx1_q) | (HID_W'(1) << (HID_W - 1));
      end else begin
        rgb_d = color_q[NUM_TANKS];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_q <= '0;
      hid_q <= '0;
    end else begin
      rgb_q <= rgb_d;
      hid_q <= hid_d;
    end
  end

  assign Red          = rgb_q[RGB_W-1 -: COLOR_W];
  assign Green        = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign Blue         = rgb_q[COLOR_W-1:0];
  assign hit_id       = hid_q;
  assign flash_active = flash_active_q;

endmodule

// File: tb/tb_tank_sprite_mapper.sv
// Directed bench for tank_sprite_mapper: hit/priority, latency, flash, config, async reset.
module tb_tank_sprite_mapper;

  logic        Clk;
  logic        Reset_n;
  logic        frame_start;
  logic [9:0]  DrawX, DrawY;
  logic        blank;
  logic [19:0] TankX, TankY;
  logic [1:0]  tank_alive, hit_pulse;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [23:0] cfg_rgb;
  logic [7:0]  Red, Green, Blue;
  logic [1:0]  hit_id;
  logic [1:0]  flash_active;
  logic [23:0] rgb;

  int n_checks = 0;
  int n_fail   = 0;

  tank_sprite_mapper dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .TankX(TankX), .TankY(TankY), .tank_alive(tank_alive), .hit_pulse(hit_pulse),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_rgb(cfg_rgb),
    .Red(Red), .Green(Green), .Blue(Blue), .hit_id(hit_id), .flash_active(flash_active)
  );

  assign rgb = {Red, Green, Blue};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_tank(input int i, input int x, input int y);
    TankX[i*10 +: 10] = 10'(x);
    TankY[i*10 +: 10] = 10'(y);
  endtask

  task automatic pix(input int x, input int y, input logic b);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    tick();
    tick();
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [23:0] val);
    cfg_we  = 1'b1;
    cfg_idx = idx;
    cfg_rgb = val;
    tick();
    cfg_we  = 1'b0;
  endtask

  logic [7:0] bpat;
  int         fcnt;

  initial begin
    Reset_n = 1'b0; frame_start = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b1;
    TankX = '0; TankY = '0; tank_alive = '0; hit_pulse = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_rgb = '0;
    repeat (2) tick();
    check_eq("reset_rgb", 32'(rgb), 32'h0);
    check_eq("reset_hit_id", 32'(hit_id), 32'h0);
    check_eq("reset_flash", 32'(flash_active), 32'h0);
    Reset_n = 1'b1;

    // Basic hit and tile boundaries
    set_tank(0, 64, 64); set_tank(1, 320, 320); tank_alive = 2'b11;
    pix(70, 80, 1'b0);
    check_eq("t0_rgb", 32'(rgb), 32'h005500);
    check_eq("t0_hit_id", 32'(hit_id), 32'h2);
    pix(100, 80, 1'b0);
    check_eq("bg_rgb", 32'(rgb), 32'h000000);
    check_eq("bg_hit_id", 32'(hit_id), 32'h0);
    pix(95, 95, 1'b0);
    check_eq("tile_edge_in_id", 32'(hit_id), 32'h2);
    pix(96, 80, 1'b0);
    check_eq("tile_edge_out_right", 32'(hit_id), 32'h0);
    pix(63, 80, 1'b0);
    check_eq("tile_edge_out_left", 32'(hit_id), 32'h0);

    // Overlap priority
    set_tank(0, 128, 96); set_tank(1, 128, 96);
    pix(130, 100, 1'b0);
    check_eq("overlap_rgb", 32'(rgb), 32'h005500);
    check_eq("overlap_id", 32'(hit_id), 32'h2);
    tank_alive = 2'b10;
    pix(130, 100, 1'b0);
    check_eq("dead0_rgb", 32'(rgb), 32'h000055);
    check_eq("dead0_id", 32'(hit_id), 32'h3);
    tank_alive = 2'b11;
    set_tank(0, 64, 64);

    // Blank and two-cycle latency
    pix(70, 80, 1'b1);
    check_eq("blank_rgb", 32'(rgb), 32'h0);
    check_eq("blank_id", 32'(hit_id), 32'h0);
    bpat = 8'b1001_0110;
    for (int j = 0; j < 8; j++) begin
      blank = bpat[j];
      tick();
      if (j >= 1) check_eq($sformatf("lag_%0d", j), 32'(rgb), bpat[j-1] ? 32'h0 : 32'h005500);
    end

    // Flash on tank1
    set_tank(1, 128, 96);
    DrawX = 10'd130; DrawY = 10'd100; blank = 1'b0;
    hit_pulse = 2'b10; tick(); hit_pulse = 2'b00;
    check_eq("flash_load_active", 32'(flash_active), 32'h2);
    tick(); tick();
    check_eq("flash8_rgb", 32'(rgb), 32'h000055);
    for (int k = 1; k <= 8; k++) begin
      fcnt = 8 - k;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      check_eq($sformatf("flash_active_%0d", fcnt), 32'(flash_active), (fcnt != 0) ? 32'h2 : 32'h0);
      tick(); tick();
      check_eq($sformatf("flash_rgb_%0d", fcnt), 32'(rgb), fcnt[0] ? 32'hFFFFFF : 32'h000055);
    end
    check_eq("flash_end_id", 32'(hit_id), 32'h3);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check_eq("flash_saturate", 32'(flash_active), 32'h0);

    // Load wins over decrement
    hit_pulse = 2'b10; frame_start = 1'b1; tick(); hit_pulse = 2'b00; frame_start = 1'b0;
    check_eq("coinc_active", 32'(flash_active), 32'h2);
    tick(); tick();
    check_eq("coinc_rgb8", 32'(rgb), 32'h000055);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick(); tick();
    check_eq("coinc_rgb7", 32'(rgb), 32'hFFFFFF);
    repeat (7) begin
      frame_start = 1'b1; tick(); frame_start = 1'b0;
    end
    check_eq("coinc_drained", 32'(flash_active), 32'h0);

    // Colour configuration
    cfg_write(2'd2, 24'h102030);
    pix(400, 400, 1'b0);
    check_eq("cfg_bg", 32'(rgb), 32'h102030);
    cfg_write(2'd3, 24'hABCDEF);
    pix(400, 400, 1'b0);
    check_eq("cfg_bad_bg", 32'(rgb), 32'h102030);
    pix(130, 100, 1'b0);
    check_eq("cfg_bad_t1", 32'(rgb), 32'h000055);
    pix(70, 80, 1'b0);
    check_eq("cfg_bad_t0", 32'(rgb), 32'h005500);
    cfg_write(2'd0, 24'h112233);
    pix(70, 80, 1'b0);
    check_eq("cfg_t0", 32'(rgb), 32'h112233);

    // Async reset in the middle of a flash
    hit_pulse = 2'b01; tick(); hit_pulse = 2'b00;
    check_eq("rst_pre_active", 32'(flash_active), 32'h1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick(); tick();
    check_eq("rst_pre_white", 32'(rgb), 32'hFFFFFF);
    #2;
    Reset_n = 1'b0;
    #1;
    check_eq("async_rst_rgb", 32'(rgb), 32'h0);
    check_eq("async_rst_flash", 32'(flash_active), 32'h0);
    check_eq("async_rst_id", 32'(hit_id), 32'h0);
    tick();
    Reset_n = 1'b1;
    tick();
    check_eq("post_rst_1cyc", 32'(rgb), 32'h0);
    tick();
    check_eq("post_rst_t0_default", 32'(rgb), 32'h005500);
    pix(400, 400, 1'b0);
    check_eq("post_rst_bg_default", 32'(rgb), 32'h000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tank_sprite_mapper.md
Name: tank_sprite_mapper

Overview:
Parametrised, pipelined pixel colour mapper for up to NUM_TANKS square tank sprites on the 640x480 VGA raster. It replaces the fixed two-tank combinational mapper and adds programmable per-tank and background colour registers, per-tank alive masking and a frame-counted hit-flash effect. It sits between the VGA controller (DrawX/DrawY/blank/frame_start) and the DAC RGB outputs. Its 2-cycle pixel latency is compensated by delaying sync in the VGA path.

Parameters:
NUM_TANKS, 2, number of sprite channels (1..8)
COORD_W, 10, width of X/Y coordinates
SPRITE_LOG2, 5, sprite edge = 2**SPRITE_LOG2 pixels (32x32 tile-aligned boxes)
COLOR_W, 8, bits per colour component
FLASH_FRAMES, 8, frames a tank flashes after a hit (1..255)

Ports:
Clk  in  1  system/pixel clock
Reset_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at start of each frame
DrawX  in  COORD_W  current pixel X
DrawY  in  COORD_W  current pixel Y
blank  in  1  1 = blanking interval, force black
TankX  in  NUM_TANKS*COORD_W  tank i X at bits [i*COORD_W +: COORD_W]
TankY  in  NUM_TANKS*COORD_W  tank i Y, same packing
tank_alive  in  NUM_TANKS  1 = tank i drawn
hit_pulse  in  NUM_TANKS  one-cycle pulse, tank i was hit
cfg_we  in  1  colour register write strobe
cfg_idx  in  $clog2(NUM_TANKS+1)  0..NUM_TANKS-1 = tank colour, NUM_TANKS = background
cfg_rgb  in  3*COLOR_W  {R,G,B} write data
Red  out  COLOR_W  red output
Green  out  COLOR_W  green output
Blue  out  COLOR_W  blue output
hit_id  out  $clog2(NUM_TANKS)+1  MSB=1 when pixel is a tank; low bits = tank index (aligned with RGB)
flash_active  out  NUM_TANKS  1 while tank i flash counter is nonzero

Behaviour:
- Reset (async, Reset_n=0): Red/Green/Blue=0, hit_id=0, flash_active=0, all flash counters=0, pipeline valid/blank regs = blank (black). Colour registers reset to: tank0 {00,55,00}, tank1 {00,00,55}, tanks>=2 {55,55,55}, background {00,00,00} (for COLOR_W=8; otherwise the same values zero-extended or truncated).
- Sprite hit for tank i: tank_alive[i] && DrawX[COORD_W-1:SPRITE_LOG2]==TankX_i[COORD_W-1:SPRITE_LOG2] && the same comparison on Y. Comparison is by tile, so a sprite occupies the aligned tile containing its coordinate.
- Priority: when several tanks hit, the lowest index wins.
- Pipeline: stage 1 registers blank, hit flag and winning index. Stage 2 looks up colour and registers RGB/hit_id. Latency is exactly 2 Clk from DrawX/DrawY/blank to RGB. Throughput is 1 pixel/cycle with no stalls.
- Output select at stage 2, in priority order:
  - blank=1: black, hit_id=0.
  - Tank hit with flash counter odd: full white (all ones).
  - Tank hit otherwise: tank colour register.
  - No tank hit: background register.
- Flash counter per tank is 8 bits.
  - hit_pulse[i]: load FLASH_FRAMES.
  - frame_start with counter nonzero: decrement.
  - hit_pulse and frame_start in the same cycle: load wins, no decrement.
  - Counter saturates at 0.
  - flash_active[i] = (counter != 0), registered with the counter.
  - A tank with tank_alive[i]=0 keeps counting but is not drawn.
- Colour write: when cfg_we=1 and cfg_idx<=NUM_TANKS, the register is updated at the clock edge. Any pixel whose stage-2 capture occurs on a later edge uses the new value. cfg_idx>NUM_TANKS is ignored with no side effect.
- Coordinate arithmetic is unsigned only; no subtraction. Coordinates >= 640/480 simply never match valid raster pixels.
- Reset mid-frame: all state clears immediately and outputs go black. After release, the first valid RGB appears 2 cycles later.

Test Plan:
- Reset then pixel stream: Tank0=(64,64) alive, DrawX=70, DrawY=80, blank=0 -> 2 cycles later RGB={00,55,00}, hit_id=1_0. DrawX=100 -> background {00,00,00}.
- Overlap priority: Tank0 and Tank1 both at (128,96), pixel (130,100) -> tank0 colour. Clear tank_alive[0] -> tank1 colour {00,00,55}, hit_id=1_1.
- Blank and latency: pixel inside tank0 with blank=1 -> RGB=0, hit_id=0. Toggling blank per cycle shows output toggling with exactly 2-cycle lag.
- Flash: hit_pulse[1] with FLASH_FRAMES=8 -> flash_active[1]=1. Tank1 pixels are white on odd counter frames (7,5,3,1) and colour on even frames. After 8 frame_start pulses, flash_active[1]=0. hit_pulse coincident with frame_start -> counter=8.
- Colour config: write cfg_idx=NUM_TANKS, cfg_rgb={10,20,30} -> background pixels become {10,20,30}. Write with cfg_idx=NUM_TANKS+1 -> no register changes.
- Async reset mid-flash: assert Reset_n=0 between clock edges -> RGB=0 and flash_active=0 immediately. Colour registers return to their reset defaults.
